flag_unit: RTL

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_pkg.sv | 13 +
 rtl/flag_calc.sv | 30 +++
 rtl/flag_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/flag_pkg.sv
// Shared types and defaults for the branch condition-flag unit.
// The PEND_MAX default lives here so the top and the bench agree on it.
package flag_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  localparam int PEND_MAX_DEF = 3;

endpackage

// File: rtl/flag_calc.sv
// Combinational Z/N/V calculation from ALU operands and result.
// Only the sign bits of a and b matter for overflow.
module flag_calc #(
  parameter int WIDTH = 32
) (
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic sa, sb, sr;
  logic unused_lo;

  assign sa = a[WIDTH-1];
  assign sb = b[WIDTH-1];
  assign sr = res[WIDTH-1];

  assign unused_lo = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

  assign z = (res == '0);
  assign n = sr;

  // Sub overflows when operand signs differ, add when they match.
  assign v = (op_sub ? (sa != sb) : (sa == sb)) && (sr != sa);

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with in-flight tracking of flag setters.
// FLAG_BYPASS_EN presents a retiring result's flags in the same cycle.
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             issue_ready,
  input  logic             upd_valid,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             stall,
  input  logic             flush,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             flags_valid,
  output logic             err
);

  localparam int CW = $clog2(PEND_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(PEND_MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;
  flags_t        flg_q;
  flags_t        flg_c;
  flags_t        flg_o;
  logic          issue_acc;

  flag_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op_sub(op_sub),
    .a     (a),
    .b     (b),
    .res   (res),
    .z     (flg_c.z),
    .n     (flg_c.n),
    .v     (flg_c.v)
  );

  assign issue_ready = !stall && (count < CMAX);
  assign issue_acc   = issue && issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      flg_q <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (!stall) begin
      if (upd_valid)
        flg_q <= flg_c;
      if (issue && !issue_ready)
        err <= 1'b1;
      // A retire with nothing outstanding is a protocol slip.
      if (upd_valid && !issue_acc && count == '0)
        err <= 1'b1;
      unique case ({issue_acc, upd_valid})
        2'b10: count <= count + ONE;
        2'b01: if (count != '0) count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FLAG_BYPASS_EN
  logic upd_fire;

  assign upd_fire    = upd_valid && !stall && !flush;
  assign flg_o       = upd_fire ? flg_c : flg_q;
  assign flags_valid = (count == '0) ||
                       (upd_fire && count == ONE && !issue_acc);
`else
  assign flg_o       = flg_q;
  assign flags_valid = (count == '0);
`endif

  assign Z = flg_o.z;
  assign N = flg_o.n;
  assign V = flg_o.v;

endmodule
